regfile_access_arbiter: RTL and testbench

Sequences and shares the single register-file control port (one address, one write-enable, one write-data) between two requesters: the AXI control path (requester A) and the fault injection module (requester B).
Each granted access follows a fixed sequence: stop the CPU, wait for the register file to settle, perform one access, return a response, release the CPU.
Sits between the requesters and the core's cm_* register-file port; it is the only driver of the CPU stop signal.

---
 rtl/regfile_access_arbiter_if.sv | 25 ++
 rtl/regfile_access_arbiter.sv | 165 ++++++++++++++++
 tb/tb_regfile_access_arbiter.sv | 325 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/regfile_access_arbiter_if.sv
// Request/response channel between one requester and the register-file access arbiter.
// The requester drives the master modport; the arbiter uses the slave modport.
interface regfile_access_arbiter_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5
);
  logic                  req_valid;
  logic                  req_ready;
  logic                  req_we;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic [DATA_WIDTH-1:0] req_wdata;
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [DATA_WIDTH-1:0] rsp_rdata;

  modport master (
    output req_valid, req_we, req_addr, req_wdata, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata
  );
endinterface

// File: rtl/regfile_access_arbiter.sv
// Shares the single register-file control port between requester A (AXI control
// path) and requester B (fault injection). Each granted access stops the CPU,
// waits SETTLE_CYCLES, performs one access, returns a response and releases the CPU.
// Optional build macro ARB_ROUND_ROBIN_EN: round-robin arbitration instead of the
// default fixed priority (B over A).
module regfile_access_arbiter #(
  parameter int DATA_WIDTH    = 32,
  parameter int ADDR_WIDTH    = 5,
  parameter int SETTLE_CYCLES = 1   // legal range 1..15
) (
  input  logic                    clk,
  input  logic                    rst_n,
  regfile_access_arbiter_if.slave a_if,
  regfile_access_arbiter_if.slave b_if,
  output logic                    cpu_stop,
  output logic [ADDR_WIDTH-1:0]   rf_addr,
  output logic                    rf_we,
  output logic [DATA_WIDTH-1:0]   rf_wdata,
  input  logic [DATA_WIDTH-1:0]   rf_rdata,
  output logic                    busy,
  output logic [1:0]              deb_state
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_SETTLE = 2'b01,
    ST_ACCESS = 2'b10,
    ST_RESP   = 2'b11
  } state_e;

  typedef enum logic {
    REQ_A = 1'b0,
    REQ_B = 1'b1
  } req_e;

  localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE_CYCLES);

  state_e                state_q, state_d;
  logic [3:0]            settle_cnt_q, settle_cnt_d;
  logic                  we_q, we_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  req_e                  winner_q, winner_d;
  logic [DATA_WIDTH-1:0] a_rdata_q, a_rdata_d;
  logic [DATA_WIDTH-1:0] b_rdata_q, b_rdata_d;

  logic grant_a;
  logic grant_b;

`ifdef ARB_ROUND_ROBIN_EN
  req_e rr_prio_q, rr_prio_d;

  // Round robin: on contention the requester not served last wins.
  always_comb begin
    grant_b = b_if.req_valid && (!a_if.req_valid || (rr_prio_q == REQ_B));
    grant_a = a_if.req_valid && !grant_b;
  end

  // Pointer moves to the other requester on every accepted request.
  always_comb begin
    rr_prio_d = rr_prio_q;
    if ((state_q == ST_IDLE) && (grant_a || grant_b)) begin
      rr_prio_d = grant_b ? REQ_A : REQ_B;
    end
  end

  // Round-robin pointer register; A has priority out of reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rr_prio_q <= REQ_A;
    else        rr_prio_q <= rr_prio_d;
  end
`else
  // Fixed priority: B wins whenever it is valid.
  always_comb begin
    grant_b = b_if.req_valid;
    grant_a = a_if.req_valid && !grant_b;
  end
`endif

  // Next-state and datapath update for the access sequence.
  always_comb begin
    // NOTE: every signal written here gets a default first so no path leaves it unassigned, which would infer a latch.
    state_d      = state_q;
    settle_cnt_d = settle_cnt_q;
    we_d         = we_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    winner_d     = winner_q;
    a_rdata_d    = a_rdata_q;
    b_rdata_d    = b_rdata_q;

    unique case (state_q)
      ST_IDLE: begin
        if (grant_a || grant_b) begin
          we_d         = grant_b ? b_if.req_we    : a_if.req_we;
          addr_d       = grant_b ? b_if.req_addr  : a_if.req_addr;
          wdata_d      = grant_b ? b_if.req_wdata : a_if.req_wdata;
          winner_d     = grant_b ? REQ_B : REQ_A;
          settle_cnt_d = SETTLE_LOAD;
          state_d      = ST_SETTLE;
        end
      end

      ST_SETTLE: begin
        settle_cnt_d = settle_cnt_q - 4'd1;
        if (settle_cnt_q == 4'd1) state_d = ST_ACCESS;
      end

      ST_ACCESS: begin
        // Writes answer with zero; reads return what the register file shows now.
        if (winner_q == REQ_A) a_rdata_d = we_q ? '0 : rf_rdata;
        else                   b_rdata_d = we_q ? '0 : rf_rdata;
        state_d = ST_RESP;
      end

      ST_RESP: begin
        // Returning to IDLE guarantees one cpu_stop-free cycle before the next grant.
        if ((winner_q == REQ_A) ? a_if.rsp_ready : b_if.rsp_ready) state_d = ST_IDLE;
      end

      default: state_d = ST_IDLE;
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: the latched request and response data are reset too, so rf_* and rsp_rdata read as zero out of reset.
      state_q      <= ST_IDLE;
      settle_cnt_q <= '0;
      we_q         <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      winner_q     <= REQ_A;
      a_rdata_q    <= '0;
      b_rdata_q    <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values regardless of statement order.
      state_q      <= state_d;
      settle_cnt_q <= settle_cnt_d;
      we_q         <= we_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      winner_q     <= winner_d;
      a_rdata_q    <= a_rdata_d;
      b_rdata_q    <= b_rdata_d;
    end
  end

  // Outputs decode straight from the state register, so reset clears them at once.
  assign a_if.req_ready = (state_q == ST_IDLE) && grant_a;
  assign b_if.req_ready = (state_q == ST_IDLE) && grant_b;
  assign a_if.rsp_valid = (state_q == ST_RESP) && (winner_q == REQ_A);
  assign b_if.rsp_valid = (state_q == ST_RESP) && (winner_q == REQ_B);
  assign a_if.rsp_rdata = a_rdata_q;
  assign b_if.rsp_rdata = b_rdata_q;

  assign cpu_stop  = (state_q != ST_IDLE);
  assign busy      = (state_q != ST_IDLE);
  assign rf_we     = (state_q == ST_ACCESS) && we_q;
  assign rf_addr   = addr_q;
  assign rf_wdata  = wdata_q;
  assign deb_state = state_q;

endmodule

// File: tb/tb_regfile_access_arbiter.sv
// Self-checking bench for regfile_access_arbiter: a transaction-level model predicts
// the state timeline, rf port activity, arbitration and responses of the main
// instance (SETTLE_CYCLES = 1); a second instance checks SETTLE_CYCLES = 4 timing.
module tb_regfile_access_arbiter;

  localparam int DW = 32;
  localparam int AW = 5;
  localparam int S1 = 1;
  localparam int S4 = 4;
  localparam logic [1:0] IDLE = 2'd0, SETTLE = 2'd1, ACCESS = 2'd2, RESP = 2'd3;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  regfile_access_arbiter_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) a_if ();
  regfile_access_arbiter_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) b_if ();
  regfile_access_arbiter_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) a4_if ();
  regfile_access_arbiter_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) b4_if ();

  logic          cpu_stop, rf_we, busy;
  logic [AW-1:0] rf_addr;
  logic [DW-1:0] rf_wdata, rf_rdata;
  logic [1:0]    deb_state;

  logic          cpu_stop4, rf_we4, busy4;
  logic [AW-1:0] rf_addr4;
  logic [DW-1:0] rf_wdata4, rf_rdata4;
  logic [1:0]    deb_state4;

  regfile_access_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .SETTLE_CYCLES(S1)) dut (
    .clk(clk), .rst_n(rst_n), .a_if(a_if), .b_if(b_if),
    .cpu_stop(cpu_stop), .rf_addr(rf_addr), .rf_we(rf_we), .rf_wdata(rf_wdata),
    .rf_rdata(rf_rdata), .busy(busy), .deb_state(deb_state)
  );

  regfile_access_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .SETTLE_CYCLES(S4)) dut4 (
    .clk(clk), .rst_n(rst_n), .a_if(a4_if), .b_if(b4_if),
    .cpu_stop(cpu_stop4), .rf_addr(rf_addr4), .rf_we(rf_we4), .rf_wdata(rf_wdata4),
    .rf_rdata(rf_rdata4), .busy(busy4), .deb_state(deb_state4)
  );

  // Register file attached to the main instance: combinational read, x0 ignores writes.
  logic [DW-1:0] rf_mem [32];
  assign rf_rdata = rf_mem[rf_addr];
  always @(posedge clk) if (rf_we && (rf_addr != '0)) rf_mem[rf_addr] = rf_wdata;

  // The second instance sees a fixed address-dependent pattern.
  assign rf_rdata4 = 32'hA500_0000 + 32'(rf_addr4);

  // ---------------- reference model / scoreboard ----------------
  typedef struct packed {
    logic          who;      // 0 = A, 1 = B
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [DW-1:0] rdata;
    int            hs;       // cycle of the request handshake
    logic          applied;
  } txn_t;

  txn_t          sb_q[$];
  logic [DW-1:0] ref_mem [32];
  int            cyc = 0;
  int            nvec = 0;
  int            nfail = 0;
  int            done_cnt = 0;
  bit            prefer_b = 1'b0;
  int            rsp_mode = 0;   // 0: always ready, 1: random, 2: never

  txn_t       mon_t;
  logic [1:0] mon_st;
  logic       mon_ea, mon_eb;

  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    nvec++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s at cycle %0d: got %h, expected %h", name, cyc, act, exp);
    end
  endtask

  // Monitor: derive the expected cycle from the outstanding transaction and compare.
  always @(negedge clk) begin
    if (!rst_n) begin
      sb_q.delete();
      prefer_b = 1'b0;
      check("rst_state",    deb_state, IDLE);
      check("rst_cpu_stop", cpu_stop, 0);
      check("rst_rf_we",    rf_we, 0);
      check("rst_busy",     busy, 0);
      check("rst_a_rsp_v",  a_if.rsp_valid, 0);
      check("rst_b_rsp_v",  b_if.rsp_valid, 0);
      check("rst_rf_addr",  rf_addr, 0);
      check("rst_rf_wdata", rf_wdata, 0);
      check("rst_a_rdata",  a_if.rsp_rdata, 0);
      check("rst_b_rdata",  b_if.rsp_rdata, 0);
    end else begin
      mon_t = '0;
      if (sb_q.size() != 0) mon_t = sb_q[0];
      if (sb_q.size() == 0)              mon_st = IDLE;
      else if (cyc <= mon_t.hs + S1)     mon_st = SETTLE;
      else if (cyc == mon_t.hs + S1 + 1) mon_st = ACCESS;
      else                               mon_st = RESP;

      check("state",    deb_state, mon_st);
      check("cpu_stop", cpu_stop, (mon_st != IDLE));
      check("busy",     busy, (mon_st != IDLE));
      check("rf_we",    rf_we, (mon_st == ACCESS) && mon_t.we);
      if (mon_st == SETTLE || mon_st == ACCESS) check("rf_addr", rf_addr, mon_t.addr);
      if (mon_st == ACCESS) begin
        if (mon_t.we) check("rf_wdata", rf_wdata, mon_t.wdata);
        mon_t.rdata = mon_t.we ? '0 : ref_mem[mon_t.addr];
        sb_q[0] = mon_t;
      end
      if (mon_st == RESP && !mon_t.applied) begin
        if (mon_t.we && mon_t.addr != '0) ref_mem[mon_t.addr] = mon_t.wdata;
        mon_t.applied = 1'b1;
        sb_q[0] = mon_t;
      end

      check("a_rsp_valid", a_if.rsp_valid, (mon_st == RESP) && !mon_t.who);
      check("b_rsp_valid", b_if.rsp_valid, (mon_st == RESP) && mon_t.who);
      if (mon_st == RESP) begin
        if (mon_t.who) check("b_rsp_rdata", b_if.rsp_rdata, mon_t.rdata);
        else           check("a_rsp_rdata", a_if.rsp_rdata, mon_t.rdata);
        if (mon_t.who ? b_if.rsp_ready : a_if.rsp_ready) begin
          void'(sb_q.pop_front());
          done_cnt++;
        end
      end

      mon_ea = 1'b0;
      mon_eb = 1'b0;
      if (mon_st == IDLE) begin
`ifdef ARB_ROUND_ROBIN_EN
        mon_eb = b_if.req_valid && (!a_if.req_valid || prefer_b);
`else
        mon_eb = b_if.req_valid;
`endif
        mon_ea = a_if.req_valid && !mon_eb;
      end
      check("a_req_ready", a_if.req_ready, mon_ea);
      check("b_req_ready", b_if.req_ready, mon_eb);
      if (mon_ea || mon_eb) begin
        mon_t       = '0;
        mon_t.who   = mon_eb;
        mon_t.we    = mon_eb ? b_if.req_we    : a_if.req_we;
        mon_t.addr  = mon_eb ? b_if.req_addr  : a_if.req_addr;
        mon_t.wdata = mon_eb ? b_if.req_wdata : a_if.req_wdata;
        mon_t.hs    = cyc;
        sb_q.push_back(mon_t);
        prefer_b = mon_ea;
      end
    end
  end

  // Response-ready drivers for both requesters.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      a_if.rsp_ready = (rsp_mode == 0) ? 1'b1 : (rsp_mode == 2) ? 1'b0 : ($urandom_range(2) == 0);
      b_if.rsp_ready = (rsp_mode == 0) ? 1'b1 : (rsp_mode == 2) ? 1'b0 : ($urandom_range(2) == 0);
    end
  end

  // Present one request and hold it until accepted (bounded).
  task automatic issue(input bit who, input bit we, input logic [AW-1:0] addr, input logic [DW-1:0] wdata);
    bit got = 1'b0;
    @(posedge clk);
    #1;
    if (who) begin
      b_if.req_valid = 1'b1; b_if.req_we = we; b_if.req_addr = addr; b_if.req_wdata = wdata;
    end else begin
      a_if.req_valid = 1'b1; a_if.req_we = we; a_if.req_addr = addr; a_if.req_wdata = wdata;
    end
    for (int i = 0; i < 300 && !got; i++) begin
      @(negedge clk);
      got = who ? b_if.req_ready : a_if.req_ready;
    end
    check("req_accepted_in_budget", got, 1);
    @(posedge clk);
    #1;
    if (who) b_if.req_valid = 1'b0;
    else     a_if.req_valid = 1'b0;
  endtask

  task automatic wait_done(input int n);
    for (int i = 0; i < 400 && done_cnt < n; i++) @(negedge clk);
    check("responses_completed", done_cnt, n);
  endtask

  task automatic random_driver(input bit who, input int n);
    for (int k = 0; k < n; k++) begin
      repeat ($urandom_range(3)) @(posedge clk);
      issue(who, 1'($urandom_range(1)), AW'($urandom_range(31)), $urandom);
    end
  endtask

  // Directed check of the SETTLE_CYCLES = 4 instance.
  task automatic settle4_test();
    bit got = 1'b0;
    bit seen = 1'b0;
    int n_settle = 0;
    int n_access = 0;
    int n_we = 0;
    @(posedge clk);
    #1;
    a4_if.req_valid = 1'b1; a4_if.req_we = 1'b0; a4_if.req_addr = 5'd3; a4_if.rsp_ready = 1'b1;
    for (int i = 0; i < 50 && !got; i++) begin
      @(negedge clk);
      got = a4_if.req_ready;
    end
    check("dut4_accept", got, 1);
    @(posedge clk);
    #1;
    a4_if.req_valid = 1'b0;
    for (int i = 1; i <= 40 && !seen; i++) begin
      @(negedge clk);
      if (deb_state4 == SETTLE) n_settle++;
      if (deb_state4 == ACCESS) begin
        n_access++;
        check("dut4_access_cycle", i, S4 + 1);
      end
      if (rf_we4) n_we++;
      if (a4_if.rsp_valid) begin
        seen = 1'b1;
        check("dut4_rsp_cycle", i, S4 + 2);
        check("dut4_rdata", a4_if.rsp_rdata, 32'hA500_0003);
      end
    end
    check("dut4_rsp_seen", seen, 1);
    check("dut4_settle_cycles", n_settle, S4);
    check("dut4_access_cycles", n_access, 1);
    check("dut4_rf_we_pulses", n_we, 0);
    @(negedge clk);
    check("dut4_back_idle", deb_state4, IDLE);
    check("dut4_cpu_released", cpu_stop4, 0);
  endtask

  initial begin
    a_if.req_valid = 0; a_if.req_we = 0; a_if.req_addr = '0; a_if.req_wdata = '0; a_if.rsp_ready = 0;
    b_if.req_valid = 0; b_if.req_we = 0; b_if.req_addr = '0; b_if.req_wdata = '0; b_if.rsp_ready = 0;
    a4_if.req_valid = 0; a4_if.req_we = 0; a4_if.req_addr = '0; a4_if.req_wdata = '0; a4_if.rsp_ready = 0;
    b4_if.req_valid = 0; b4_if.req_we = 0; b4_if.req_addr = '0; b4_if.req_wdata = '0; b4_if.rsp_ready = 0;
    for (int i = 0; i < 32; i++) begin
      rf_mem[i]  = (i == 0) ? '0 : $urandom;
      ref_mem[i] = rf_mem[i];
    end
    rf_mem[5]  = 32'hDEAD_BEEF;
    ref_mem[5] = 32'hDEAD_BEEF;

    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // A reads x5, then B writes x10.
    rsp_mode = 0;
    issue(1'b0, 1'b0, 5'd5, '0);
    wait_done(1);
    issue(1'b1, 1'b1, 5'd10, 32'h1234_5678);
    wait_done(2);

    // Simultaneous requests from both sides.
    fork
      issue(1'b0, 1'b0, 5'd10, '0);
      issue(1'b1, 1'b1, 5'd5, 32'hCAFE_F00D);
    join
    wait_done(4);

    // Response held for 10+ cycles while B waits.
    rsp_mode = 2;
    issue(1'b0, 1'b0, 5'd5, '0);
    fork
      issue(1'b1, 1'b0, 5'd10, '0);
      begin
        repeat (S1 + 13) @(negedge clk);
        rsp_mode = 0;
      end
    join
    wait_done(6);

    // Randomized traffic with random response back-pressure.
    rsp_mode = 1;
    fork
      random_driver(1'b0, 40);
      random_driver(1'b1, 40);
    join
    wait_done(86);

    // Reset during the ACCESS cycle of a write.
    rsp_mode = 0;
    issue(1'b1, 1'b1, 5'd7, 32'h0BAD_F00D);
    for (int i = 0; i < 20 && deb_state != ACCESS; i++) @(negedge clk);
    check("reached_access", deb_state, ACCESS);
    #2 rst_n = 1'b0;
    #1;
    check("rst_drops_rf_we",    rf_we, 0);
    check("rst_drops_cpu_stop", cpu_stop, 0);
    check("rst_state_idle",     deb_state, IDLE);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("no_rsp_after_rst", b_if.rsp_valid, 0);
    issue(1'b0, 1'b0, 5'd7, '0);
    wait_done(87);

    settle4_test();

    repeat (3) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: run did not complete, %0d vectors, %0d miscompares", nvec, nfail);
    $fatal(1, "watchdog expired");
  end

endmodule
